// File: rtl/alu_mul_sequencer_if.sv
// Request/response handshake bundle for the shift-and-add multiplier sequencer.
// The caller drives the master side; the sequencer implements the slave side.
interface alu_mul_sequencer_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_a;
   logic [N-1:0] in_b;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_product;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_product
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_product
   );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-and-add multiplier that borrows the shared alu adder.
// Returns the low N bits of a*b; terminates early once the multiplier runs out of ones.
package alu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SLT = 4'd5
   } alu_control_t;
endpackage

module alu_mul_sequencer #(
   parameter int N = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_mul_sequencer_if.slave    bus,
   output logic                  busy,
   output logic [N-1:0]          alu_a,
   output logic [N-1:0]          alu_b,
   output alu_pkg::alu_control_t alu_control,
   input  logic [N-1:0]          alu_result
);
   import alu_pkg::*;

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_reg,   state_next;
   logic [N-1:0]  acc_reg,     acc_next;
   logic [N-1:0]  mcand_reg,   mcand_next;
   logic [N-1:0]  mplier_reg,  mplier_next;
   logic [CW-1:0] count_reg,   count_next;
   logic [N-1:0]  product_reg, product_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         acc_reg     <= '0;
         mcand_reg   <= '0;
         mplier_reg  <= '0;
         count_reg   <= '0;
         product_reg <= '0;
      end else begin
         state_reg   <= state_next;
         acc_reg     <= acc_next;
         mcand_reg   <= mcand_next;
         mplier_reg  <= mplier_next;
         count_reg   <= count_next;
         product_reg <= product_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      acc_next      = acc_reg;
      mcand_next    = mcand_reg;
      mplier_next   = mplier_reg;
      count_next    = count_reg;
      product_next  = product_reg;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b0;
      alu_a         = '0;
      alu_b         = '0;
      alu_control   = ALU_ADD;

      unique case (state_reg)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               acc_next    = '0;
               mcand_next  = bus.in_a;
               mplier_next = bus.in_b;
               count_next  = '0;
               state_next  = RUN;
            end
         end
         RUN: begin
            busy        = 1'b1;
            alu_a       = acc_reg;
            alu_b       = mcand_reg;
            if (mplier_reg[0]) begin
               acc_next = alu_result;
            end
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            count_next  = count_reg + CW'(1);
            // Stop as soon as no multiplier ones remain, or after the last bit.
            if ((mplier_reg >> 1) == '0 || count_reg == CW'(N - 1)) begin
               product_next = acc_next;
               state_next   = DONE;
            end
         end
         DONE: begin
            busy          = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The result lives in its own register so it survives acc being cleared on the next accept.
   assign bus.out_product = product_reg;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural adder standing in for the alu.
module tb_alu_mul_sequencer;
   import alu_pkg::*;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         busy;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   alu_control_t alu_control;
   logic [N-1:0] alu_result;

   int checks = 0;
   int errors = 0;

   alu_mul_sequencer_if #(.N(N)) bus ();

   alu_mul_sequencer #(.N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .busy        (busy),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_control (alu_control),
      .alu_result  (alu_result)
   );

   always #5 clk = ~clk;

   // Adder model of the shared alu; anything other than ADD yields garbage on purpose.
   assign alu_result = (alu_control == ALU_ADD) ? alu_a + alu_b : 32'hDEAD_BEEF;

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for out_valid; cycles counts edges from the accept edge inclusive.
   task automatic wait_done(input string tag, inout int cycles);
      while (bus.out_valid !== 1'b1 && cycles < 200) begin
         tick();
         cycles++;
      end
      check({tag, "_done_seen"}, 32'(bus.out_valid), 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp, input int run_len);
      int cycles;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_a     = ~a;
      bus.in_b     = 32'h5A5A_5A5A;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_alu_a0"}, alu_a, 32'd0);
      check({tag, "_alu_b0"}, alu_b, a);
      cycles = 1;
      wait_done(tag, cycles);
      check({tag, "_latency"}, 32'(cycles), 32'(run_len + 1));
      check({tag, "_product"}, bus.out_product, exp);
      check({tag, "_done_in_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_done_alu_b"}, alu_b, 32'd0);
      tick();
      check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
      check({tag, "_post_product"}, bus.out_product, exp);
      $display("op %s a=%h b=%h product=%h cycles=%0d", tag, a, b, bus.out_product, cycles);
   endtask

   initial begin
      int cycles;
      int pulses;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_product", bus.out_product, 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);
      check("rst_alu_ctl", 32'(alu_control), 32'(ALU_ADD));
      $display("reset done");

      run_op("mul_6x7", 32'd6, 32'd7, 32'd42, 3);
      run_op("mul_by0", 32'h1234_5678, 32'd0, 32'd0, 1);
      run_op("mul_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32);
      run_op("mul_neg3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 3);

      // Backpressure: hold DONE for 5 cycles with a pending request that must wait.
      bus.in_a      = 32'd10;
      bus.in_b      = 32'd11;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      tick();
      bus.in_a = 32'd3;
      bus.in_b = 32'd3;
      cycles   = 1;
      wait_done("bp", cycles);
      check("bp_latency", 32'(cycles), 32'd5);
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
         check("bp_hold_product", bus.out_product, 32'h6E);
         check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      check("bp_release_valid", 32'(bus.out_valid), 32'd1);
      tick();
      check("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
      check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
      tick();
      bus.in_valid = 1'b0;
      cycles = 1;
      wait_done("bp_next", cycles);
      check("bp_next_product", bus.out_product, 32'd9);
      $display("op backpressure first=0x6e second=%h", bus.out_product);
      tick();

      // Reset in the middle of a run discards the operation.
      bus.in_a      = 32'd9;
      bus.in_b      = 32'hFF;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      check("rstrun_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstrun_in_ready", 32'(bus.in_ready), 32'd1);
      check("rstrun_busy_low", 32'(busy), 32'd0);
      check("rstrun_valid", 32'(bus.out_valid), 32'd0);
      check("rstrun_alu_a", alu_a, 32'd0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.out_valid === 1'b1) pulses++;
         tick();
      end
      check("rstrun_no_pulse", 32'(pulses), 32'd0);
      $display("op reset_mid_run discarded");
      run_op("mul_2x3", 32'd2, 32'd3, 32'd6, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
